// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - FIFO read-side adapter feeding a registered 2-entry valid/ready stream
// Define FIFO_RD_FLUSH_EN to add the flush port (discard buffered and queued words).
module fifo_rd_skid #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] fifo_outData,
  input  logic              fifo_empty,
  output logic              single_pop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data
`ifdef FIFO_RD_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]        cnt;
  logic [DWIDTH-1:0] slot0;
  logic [DWIDTH-1:0] slot1;
  logic              flush_act;
  logic              consume;

`ifdef FIFO_RD_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // Pop depends only on registered occupancy and fifo_empty, never on out_ready.
  assign single_pop = !fifo_empty && (flush_act || (cnt != TWO));
  assign out_valid  = (cnt != EMPTY) && !flush_act;
  assign consume    = out_valid && out_ready;
  assign out_data   = slot0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush_act) begin
      cnt <= EMPTY;
    end else begin
      case (cnt)
        EMPTY: begin
          if (single_pop) begin
            cnt   <= ONE;
            slot0 <= fifo_outData;
          end
        end
        ONE: begin
          if (single_pop && !consume) begin
            cnt   <= TWO;
            slot1 <= fifo_outData;
          end else if (single_pop && consume) begin
            slot0 <= fifo_outData;
          end else if (consume) begin
            cnt <= EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            cnt   <= ONE;
            slot0 <= slot1;
          end
        end
        default: cnt <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_skid.sv
// tb/tb_fifo_rd_skid.sv - self-checking bench for fifo_rd_skid against a queue-based model
module tb_fifo_rd_skid;

  logic        clk;
  logic        rst_n;
  logic [31:0] fifo_outData;
  logic        fifo_empty;
  logic        single_pop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush_m;

  int checks;
  int failures;

  logic [31:0] fifo_q[$];
  logic [31:0] pipe[$];

  fifo_rd_skid #(.DWIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_outData (fifo_outData),
    .fifo_empty   (fifo_empty),
    .single_pop   (single_pop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef FIFO_RD_FLUSH_EN
    ,
    .flush        (flush_m)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, check, advance model at posedge, return at next negedge.
  task automatic step(input logic rdy);
    logic exp_pop, exp_valid, cons;
    out_ready    = rdy;
    fifo_empty   = (fifo_q.size() == 0);
    fifo_outData = fifo_empty ? 32'h0 : fifo_q[0];
    #1;
    exp_valid = (pipe.size() != 0) && !flush_m;
    exp_pop   = !fifo_empty && (flush_m || pipe.size() < 2);
    cons      = exp_valid && rdy;
    chk("single_pop", {31'b0, single_pop}, {31'b0, exp_pop});
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    if (exp_valid) chk("out_data", out_data, pipe[0]);
    @(posedge clk);
    if (flush_m) pipe.delete();
    else begin
      if (cons) void'(pipe.pop_front());
      if (exp_pop) pipe.push_back(fifo_q[0]);
    end
    if (exp_pop) void'(fifo_q.pop_front());
    @(negedge clk);
  endtask

  initial begin
    logic bp[7];
    checks   = 0;
    failures = 0;
    flush_m  = 1'b0;
    bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset with A,B,C waiting in the FIFO and the consumer stalled
    rst_n = 1'b0;
    out_ready = 1'b0;
    fifo_q = '{32'hA, 32'hB, 32'hC};
    fifo_empty = 1'b0;
    fifo_outData = 32'hA;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_single_pop", {31'b0, single_pop}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1);

    // Full-rate stream of 1..8
    for (int i = 1; i <= 8; i++) fifo_q.push_back(i);
    for (int i = 0; i < 11; i++) step(1'b1);

    // Backpressure over a 10-word stream
    for (int i = 0; i < 10; i++) fifo_q.push_back(32'h100 + i);
    for (int i = 0; i < 28; i++) step(bp[i % 7]);

    // FIFO empties while holding one word, then a late push
    fifo_q.push_back(32'h200);
    for (int i = 0; i < 4; i++) step(1'b0);
    step(1'b1);
    step(1'b1);
    fifo_q.push_back(32'h201);
    for (int i = 0; i < 3; i++) step(1'b1);

    // Stall into TWO then release back-to-back
    for (int i = 0; i < 5; i++) fifo_q.push_back(32'h300 + i);
    step(1'b0);
    step(1'b0);
    for (int i = 0; i < 8; i++) step(1'b1);

    // Randomized traffic with a mid-run asynchronous reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) fifo_q.push_back($urandom);
      step(1'($urandom_range(0, 1)));
      if (i == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_data", out_data, 32'd0);
        pipe.delete();
        fifo_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    for (int i = 0; i < 6; i++) step(1'b1);

`ifdef FIFO_RD_FLUSH_EN
    // Flush with two buffered words and four queued in the FIFO
    for (int i = 0; i < 6; i++) fifo_q.push_back(32'h400 + i);
    step(1'b0);
    step(1'b0);
    flush_m = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1);
    flush_m = 1'b0;
    step(1'b1);
    fifo_q.push_back(32'hD);
    for (int i = 0; i < 3; i++) step(1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
